// File: rtl/ccff_chain_loader.sv
// Serializes configuration words LSB-first into one CLB ccff chain, with an
// optional replay pass that checks the bits returning on ccff_tail.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 16,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clock,
  input  logic              global_reset,
  input  logic              start,
  input  logic              verify,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_word,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              config_enable,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int PW = $clog2(CHAIN_LEN + 1);
  localparam int WW = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;

  state_t            state, state_nxt;
  logic              vflag;
  logic [PW-1:0]     pass_left;
  logic [WW-1:0]     word_left;
  logic [WW-1:0]     word_load;
  logic [WORD_W-1:0] sr;
  logic              in_pass, shift, accept, pass_end, take_start;

  always_comb begin
    in_pass       = (state == LOAD) || (state == VERIFY);
    shift         = in_pass && (word_left != '0);
    cfg_ready     = in_pass && (word_left == '0) && (pass_left != '0);
    accept        = cfg_ready && cfg_valid;
    pass_end      = shift && (pass_left == PW'(1));
    take_start    = (state == IDLE) && start && !abort;
    config_enable = shift;
    ccff_head     = shift & sr[0];
    busy          = (state != IDLE);
    done          = (state == DONE);
    // the last word of a pass only contributes the bits the chain still needs
    word_load     = (32'(pass_left) >= 32'(WORD_W)) ? WW'(WORD_W) : WW'(pass_left);

    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (pass_end) state_nxt = vflag ? VERIFY : DONE;
      VERIFY:  if (pass_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge prog_clock) begin
    if (global_reset) state <= IDLE;
    else              state <= state_nxt;
  end

  always_ff @(posedge prog_clock) begin
    if (global_reset || abort) begin
      vflag     <= 1'b0;
      pass_left <= '0;
      word_left <= '0;
    end else if (take_start) begin
      vflag     <= verify;
      pass_left <= PW'(CHAIN_LEN);
      word_left <= '0;
    end else if (accept) begin
      word_left <= word_load;
    end else if (shift) begin
      word_left <= word_left - WW'(1);
      // end of a load pass that is followed by verify re-arms the bit count
      if (pass_end && (state == LOAD) && vflag) pass_left <= PW'(CHAIN_LEN);
      else                                      pass_left <= pass_left - PW'(1);
    end
  end

  always_ff @(posedge prog_clock) begin
    if (accept)     sr <= cfg_word;
    else if (shift) sr <= sr >> 1;
  end

  always_ff @(posedge prog_clock) begin
    if (global_reset)                                         err <= 1'b0;
    else if (take_start)                                      err <= 1'b0;
    else if (!abort && (state == VERIFY) && shift && (ccff_tail != sr[0])) err <= 1'b1;
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench for ccff_chain_loader: a 16-bit and a 12-bit chain share stimulus,
// one is selected for observation; expected head bits are queued on each accept.
module tb_ccff_chain_loader;

  logic       clk = 1'b0;
  logic       global_reset, start, verify, abort, cfg_valid;
  logic [7:0] cfg_word;

  logic rdy16, head16, ce16, busy16, done16, err16;
  logic rdy12, head12, ce12, busy12, done12, err12;
  logic [15:0] chain16;
  logic [11:0] chain12;

  always #5 clk = ~clk;

  ccff_chain_loader #(.CHAIN_LEN(16), .WORD_W(8)) dut (
    .prog_clock(clk), .global_reset(global_reset), .start(start), .verify(verify),
    .abort(abort), .cfg_word(cfg_word), .cfg_valid(cfg_valid), .cfg_ready(rdy16),
    .ccff_head(head16), .ccff_tail(chain16[0]), .config_enable(ce16),
    .busy(busy16), .done(done16), .err(err16));

  ccff_chain_loader #(.CHAIN_LEN(12), .WORD_W(8)) dut12 (
    .prog_clock(clk), .global_reset(global_reset), .start(start), .verify(verify),
    .abort(abort), .cfg_word(cfg_word), .cfg_valid(cfg_valid), .cfg_ready(rdy12),
    .ccff_head(head12), .ccff_tail(chain12[0]), .config_enable(ce12),
    .busy(busy12), .done(done12), .err(err12));

  // chain models: first bit shifted in ends at bit 0, next to the tail
  always @(posedge clk) begin
    if (ce16) chain16 <= {head16, chain16[15:1]};
    if (ce12) chain12 <= {head12, chain12[11:1]};
  end

  int   sel = 0;
  logic ready_s, head_s, ce_s, busy_s, done_s, err_s;
  assign ready_s = sel ? rdy12  : rdy16;
  assign head_s  = sel ? head12 : head16;
  assign ce_s    = sel ? ce12   : ce16;
  assign busy_s  = sel ? busy12 : busy16;
  assign done_s  = sel ? done12 : done16;
  assign err_s   = sel ? err12  : err16;

  int nerr = 0;
  int nchk = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] span(input int a, input int b);
    logic [63:0] m = '0;
    for (int i = a; i <= b; i++) m[i] = 1'b1;
    return m;
  endfunction

  logic [7:0]  words[$];
  logic        exp_q[$];
  int          acc_cycles[$];
  logic [63:0] en_mask;
  int          en_cnt, done_cyc, err_cyc;
  int          stall_after = -1;
  int          stall_len = 0;
  int          kill_at = 0;
  bit          kill_rst = 0;

  task automatic run_op(input bit vfy);
    int cyc, pass_rem, n_chain, phase, gap, wi, n;
    bit fin;
    logic [7:0] w;
    n_chain = sel ? 12 : 16;
    pass_rem = n_chain; phase = 0; gap = 0; wi = 0; fin = 0;
    exp_q.delete(); acc_cycles.delete();
    en_mask = '0; en_cnt = 0; done_cyc = -1; err_cyc = -1;
    @(negedge clk);
    start = 1'b1; verify = vfy; cfg_valid = 1'b0; cyc = 0;
    while (!fin && cyc < 150) begin
      @(negedge clk);
      cyc++; start = 1'b0; verify = 1'b0; cfg_valid = 1'b0;
      if (ce_s) begin
        en_cnt++; en_mask[cyc] = 1'b1;
        if (exp_q.size() == 0) check("head_extra", 64'd1, 64'd0);
        else check("head", head_s, exp_q.pop_front());
      end
      if (err_s && err_cyc < 0) err_cyc = cyc;
      if (done_s) begin done_cyc = cyc; fin = 1; end
      if (kill_at > 0 && en_cnt == kill_at && ce_s) begin
        if (kill_rst) global_reset = 1'b1; else abort = 1'b1;
        @(negedge clk);
        global_reset = 1'b0; abort = 1'b0;
        check("kill_busy", busy_s, 0);
        check("kill_ready", ready_s, 0);
        check("kill_ce", ce_s, 0);
        repeat (3) begin
          @(negedge clk);
          check("kill_done", done_s, 0);
        end
        exp_q.delete();
        return;
      end
      if (ready_s) begin
        if (gap > 0) begin
          check("gap_ce", ce_s, 0);
          gap--;
        end else if (wi < words.size()) begin
          w = words[wi];
          cfg_valid = 1'b1; cfg_word = w;
          acc_cycles.push_back(cyc);
          n = (pass_rem < 8) ? pass_rem : 8;
          for (int i = 0; i < n; i++) exp_q.push_back(w[i]);
          pass_rem -= n;
          if (pass_rem == 0 && vfy && phase == 0) begin phase = 1; pass_rem = n_chain; end
          if (wi == stall_after) gap = stall_len;
          wi++;
        end
      end
    end
    check("done_seen", 64'(fin), 64'd1);
    check("leftover", exp_q.size(), 0);
  endtask

  task automatic settle();
    @(negedge clk); cfg_valid = 1'b0; abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic plain_load(input string tag);
    words = '{8'hA5, 8'h3C};
    run_op(0);
    check({tag, "_done"}, done_cyc, 19);
    check({tag, "_chain"}, chain16, 16'h3CA5);
    settle();
  endtask

  initial begin
    global_reset = 1'b1; start = 1'b0; verify = 1'b0; abort = 1'b0;
    cfg_valid = 1'b0; cfg_word = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", ready_s, 0);
    check("rst_head", head_s, 0);
    check("rst_ce", ce_s, 0);
    check("rst_busy", busy_s, 0);
    check("rst_done", done_s, 0);
    check("rst_err", err_s, 0);
    global_reset = 1'b0;
    @(negedge clk);

    // plain load, no stalls
    words = '{8'hA5, 8'h3C};
    run_op(0);
    check("t1_acc0", acc_cycles.size() > 0 ? acc_cycles[0] : -1, 1);
    check("t1_acc1", acc_cycles.size() > 1 ? acc_cycles[1] : -1, 10);
    check("t1_mask", en_mask, span(2, 9) | span(11, 18));
    check("t1_ncyc", en_cnt, 16);
    check("t1_done", done_cyc, 19);
    check("t1_chain", chain16, 16'h3CA5);
    check("t1_err", err_s, 0);
    settle();

    // load plus matching verify
    words = '{8'hA5, 8'h3C, 8'hA5, 8'h3C};
    run_op(1);
    check("t2_ncyc", en_cnt, 32);
    check("t2_done", done_cyc, 37);
    check("t2_err", err_s, 0);
    check("t2_chain", chain16, 16'h3CA5);
    settle();

    // verify with a corrupted first word
    words = '{8'hA5, 8'h3C, 8'hA4, 8'h3C};
    run_op(1);
    check("t3_errcyc", err_cyc, 21);
    check("t3_done", done_cyc, 37);
    check("t3_err_done", err_s, 1);
    settle();
    check("t3_err_sticky", err_s, 1);
    words = '{8'hA5, 8'h3C};
    run_op(0);
    check("t3_err_clr", err_cyc, -1);
    check("t3_chain", chain16, 16'h3CA5);
    settle();

    // 12-bit chain, partial final word
    sel = 1;
    words = '{8'hFF, 8'hF3};
    run_op(0);
    check("t4_ncyc", en_cnt, 12);
    check("t4_mask", en_mask, span(2, 9) | span(11, 14));
    check("t4_done", done_cyc, 15);
    check("t4_chain", chain12, 12'h3FF);
    settle();
    sel = 0;

    // 5-cycle source stall between words
    stall_after = 0; stall_len = 5;
    words = '{8'hA5, 8'h3C};
    run_op(0);
    check("t5_acc1", acc_cycles.size() > 1 ? acc_cycles[1] : -1, 15);
    check("t5_ncyc", en_cnt, 16);
    check("t5_done", done_cyc, 24);
    check("t5_chain", chain16, 16'h3CA5);
    stall_after = -1; stall_len = 0;
    settle();

    // abort mid-load, then a clean load
    kill_at = 5; kill_rst = 0;
    words = '{8'hA5, 8'h3C};
    run_op(0);
    kill_at = 0;
    plain_load("t6");

    // reset mid-load clears err
    words = '{8'hA5, 8'h3C, 8'hA4, 8'h3C};
    run_op(1);
    settle();
    check("t7_err_set", err_s, 1);
    kill_at = 5; kill_rst = 1;
    words = '{8'hA5, 8'h3C};
    run_op(0);
    kill_at = 0; kill_rst = 0;
    check("t7_err_rst", err_s, 0);
    plain_load("t7");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
